// File: rtl/tx_arb_pkg.sv
// Shared types and helpers for the tx_arb_mux packet arbiter.
// Holds the FSM encoding, arbitration mode constants and width derivations.
// No logic; imported by tx_arb_sel and tx_arb_mux.
package tx_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int calc_mty_w(input int data_w);
        int w;
        w = $clog2(data_w / 8);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int calc_ch_w(input int n_ch);
        int w;
        w = $clog2(n_ch);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tx_arb_sel.sv
// Combinational winner select over a request vector (fixed priority or round robin from rr).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller qualifies the result with downstream readiness.
module tx_arb_sel
    import tx_arb_pkg::*;
#(
    parameter  int N_CH = 2,
    localparam int CH_W = calc_ch_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] rr,
    input  logic            mode,
    output logic [CH_W-1:0] idx,
    output logic            found
);

    int pos;

    // Scan candidates in priority order; in round robin the order starts at rr and wraps.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < N_CH; i++) begin
            pos = mode ? ((int'(rr) + i) % N_CH) : i;
            for (int j = 0; j < N_CH; j++) begin
                if (!found && (j == pos) && req[j]) begin
                    found = 1'b1;
                    idx   = CH_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/tx_arb_mux.sv
// Packet-atomic N_CH:1 stream mux; optional protocol checks under TX_ARB_ERR_CHK_EN (adds err_pulse).
// Latency: 1 clk from input acceptance to out_* (single output register stage).
// Backpressure: out_* hold while out_vld && !out_rdy; in_rdy is 0 until the output stage can advance.
module tx_arb_mux
    import tx_arb_pkg::*;
#(
    parameter  int N_CH     = 2,
    parameter  int DATA_W   = 32,
    parameter  int ARB_MODE = ARB_FIXED,
    localparam int MTY_W    = calc_mty_w(DATA_W),
    localparam int CH_W     = calc_ch_w(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_sop,
    input  logic [N_CH-1:0]        in_eop,
    input  logic [N_CH-1:0]        in_vld,
    input  logic [N_CH*MTY_W-1:0]  in_mty,
    output logic [N_CH-1:0]        in_rdy,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic                   out_vld,
    output logic [MTY_W-1:0]       out_mty,
    input  logic                   out_rdy,
    output logic [CH_W-1:0]        out_ch
`ifdef TX_ARB_ERR_CHK_EN
    ,
    output logic                   err_pulse
`endif
);

    arb_state_t        state;
    logic [CH_W-1:0]   g;
    logic [CH_W-1:0]   rr;

    logic [CH_W-1:0]   win_idx;
    logic              win_found;
    logic              can_adv;

    logic [CH_W-1:0]   sel_ch;
    logic [DATA_W-1:0] sel_data;
    logic [MTY_W-1:0]  sel_mty;
    logic              sel_sop;
    logic              sel_eop;
    logic              sel_vld;
    logic              fwd;
    logic              fwd_eop;
    logic              sop_err;

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
        if (int'(c) == N_CH - 1) return '0;
        return c + 1'b1;
    endfunction

    assign can_adv = !out_vld || out_rdy;

    tx_arb_sel #(.N_CH(N_CH)) u_sel (
        .req   (in_vld & in_sop),
        .rr    (rr),
        .mode  (1'(ARB_MODE == ARB_RR)),
        .idx   (win_idx),
        .found (win_found)
    );

`ifdef TX_ARB_ERR_CHK_EN
    logic [CH_W-1:0] drain_idx;
    logic            drain_found;
    logic            drain_vld;

    // Headless words only get flushed when no legal sop is waiting.
    tx_arb_sel #(.N_CH(N_CH)) u_drain_sel (
        .req   (in_vld & ~in_sop),
        .rr    ('0),
        .mode  (1'b0),
        .idx   (drain_idx),
        .found (drain_found)
    );

    assign drain_vld = (state == ST_IDLE) && !win_found && drain_found;
    assign sop_err   = (state == ST_BUSY) && sel_sop;
`else
    assign sop_err   = 1'b0;
`endif

    always_comb begin
        sel_ch   = (state == ST_IDLE) ? win_idx : g;
        sel_data = '0;
        sel_mty  = '0;
        sel_sop  = 1'b0;
        sel_eop  = 1'b0;
        sel_vld  = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (CH_W'(k) == sel_ch) begin
                sel_data = in_data[k*DATA_W +: DATA_W];
                sel_mty  = in_mty[k*MTY_W +: MTY_W];
                sel_sop  = in_sop[k];
                sel_eop  = in_eop[k];
                sel_vld  = in_vld[k];
            end
        end
    end

    assign fwd     = can_adv && ((state == ST_IDLE) ? win_found : sel_vld);
    assign fwd_eop = sel_eop || sop_err;

    always_comb begin
        in_rdy = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (state == ST_BUSY)
                in_rdy[k] = (g == CH_W'(k)) && can_adv;
            else
                in_rdy[k] = win_found && (win_idx == CH_W'(k)) && can_adv;
`ifdef TX_ARB_ERR_CHK_EN
            if (drain_vld && (drain_idx == CH_W'(k)))
                in_rdy[k] = 1'b1;
`endif
        end
        if (rst)
            in_rdy = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            g        <= '0;
            rr       <= '0;
            out_vld  <= 1'b0;
            out_sop  <= 1'b0;
            out_eop  <= 1'b0;
            out_data <= '0;
            out_mty  <= '0;
            out_ch   <= '0;
`ifdef TX_ARB_ERR_CHK_EN
            err_pulse <= 1'b0;
`endif
        end else begin
`ifdef TX_ARB_ERR_CHK_EN
            err_pulse <= drain_vld || (fwd && sop_err);
`endif
            if (fwd) begin
                out_vld  <= 1'b1;
                out_data <= sel_data;
                out_sop  <= sel_sop;
                out_eop  <= fwd_eop;
                out_mty  <= sel_mty;
                out_ch   <= sel_ch;
                g        <= sel_ch;
                // A single-word packet never leaves IDLE, so back-to-back grants are possible.
                if (fwd_eop) begin
                    state <= ST_IDLE;
                    if (ARB_MODE == ARB_RR)
                        rr <= next_ch(sel_ch);
                end else begin
                    state <= ST_BUSY;
                end
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: doc/tx_arb_mux.md
TX_ARB_MUX -- requirements
Module: tx_arb_mux

Interface
REQ-001 Parameter N_CH, default 2, number of packet input channels (2..8).
REQ-002 Parameter DATA_W, default 32, data width in bits (16, 32 or 64).
REQ-003 Parameter ARB_MODE, default 0: 0 is fixed priority (ch0 highest); 1 is round robin.
REQ-004 Derived MTY_W = log2(DATA_W/8), minimum 1; mty is the count of empty bytes in the eop word.
REQ-005 clk  in  1  sole clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_data  in  N_CH*DATA_W  per-channel data, channel k at bits [k*DATA_W +: DATA_W].
REQ-008 in_sop, in_eop, in_vld  in  N_CH each  per-channel start-of-packet, end-of-packet and valid.
REQ-009 in_mty  in  N_CH*MTY_W  per-channel empty-byte count.
REQ-010 in_rdy  out  N_CH  per-channel ready.
REQ-011 out_data/out_sop/out_eop/out_vld/out_mty  out  DATA_W/1/1/1/MTY_W  merged stream.
REQ-012 out_rdy  in  1  downstream ready.
REQ-013 out_ch  out  log2(N_CH), minimum 1  channel index of the current out word.

Function
REQ-014 An input word transfers when in_vld[k] and in_rdy[k] are both high; an output word transfers when out_vld and out_rdy are both high.
REQ-015 The FSM has two states. IDLE: no packet owns the output. BUSY: grant register g owns the output.
REQ-016 In IDLE the candidates are channels with in_vld[k] and in_sop[k] both high.
REQ-016a Mode 0 selects the lowest-index candidate.
REQ-016b Mode 1 selects the first candidate at or after pointer rr, wrapping modulo N_CH.
REQ-016c Selection loads g and moves the FSM to BUSY in the same cycle that the sop word is accepted.
REQ-017 in_rdy[k] = (k==g or k is the IDLE winner) and (out_vld==0 or out_rdy==1); all other bits are 0.
REQ-018 Output stage is one register stage: an accepted input word appears on out_* on the next cycle; latency is 1 clk.
REQ-019 out_* holds stable while out_vld is high and out_rdy is low; no data bit, flag or out_ch changes under backpressure.
REQ-020 A packet is atomic: no other channel gets in_rdy until the owner's eop word is accepted.
REQ-021 When the eop word is accepted: FSM returns to IDLE; in mode 1, rr becomes (g+1) mod N_CH; a new sop may be granted on the following cycle.
REQ-022 A single-word packet (sop and eop together) is legal: one cycle in BUSY at most, then IDLE.
REQ-023 When out_vld=1, out_rdy=0 and a new input is pending, in_rdy stays 0 and no input word is lost.
REQ-024 In mode 1 with all channels continuously requesting, grants rotate 0,1,...,N_CH-1,0 on successive packets.
REQ-025 in_mty is passed through unchanged and is meaningful only when out_eop=1.

Reset
REQ-026 While rst is high at a clk edge: out_vld, out_sop, out_eop, out_data, out_mty, out_ch = 0; in_rdy = 0; FSM = IDLE; g = 0; rr = 0.
REQ-027 Reset mid-packet discards the partial packet; the channel must restart with sop.
REQ-028 The first grant is possible on the first cycle after rst deasserts.

Configuration
REQ-029 Macro TX_ARB_ERR_CHK_EN, when defined, adds output err_pulse (1 bit) and the protocol checks in REQ-030 and REQ-031.
REQ-030 With TX_ARB_ERR_CHK_EN defined, in IDLE a channel with vld=1 and sop=0 is drained.
REQ-030a Draining means that channel's in_rdy=1, the word is dropped and err_pulse=1 for one cycle; this happens only when no sop candidate exists.
REQ-031 With TX_ARB_ERR_CHK_EN defined, in BUSY a sop=1 word from g is forwarded with out_eop forced to 1 and err_pulse=1; the FSM then returns to IDLE.
REQ-032 Without TX_ARB_ERR_CHK_EN, err_pulse and its logic are absent and non-sop words in IDLE wait with in_rdy=0.

Structure
REQ-033 Package tx_arb_pkg holds the FSM state encoding, the ARB_MODE constants (ARB_FIXED=0, ARB_RR=1) and the MTY_W derivation function.
REQ-034 Sub-module tx_arb_sel is the combinational winner select; its inputs are request vector, rr and mode, and its outputs are the index and a found flag.

Verification
REQ-035 N_CH=2, mode 0: ch0 and ch1 both present a 3-word packet on the same cycle -> ch0's 3 words out first (out_ch=0), then ch1's (out_ch=1), no gap beyond 1 idle cycle.
REQ-036 N_CH=4, mode 1: all channels send 1-word packets continuously -> out_ch sequence 0,1,2,3,0,1.
REQ-037 out_rdy held low 5 cycles mid-packet, data 0xA5A5A5A5 on out -> out_data holds 0xA5A5A5A5, in_rdy=0, word count at output equals input.
REQ-038 DATA_W=64: eop word with in_mty=5 -> out_mty=5 with out_eop=1 one cycle after acceptance.
REQ-039 rst asserted after word 2 of a 4-word ch1 packet -> all outputs 0 the next cycle; a subsequent ch0 packet is granted and forwarded intact.
REQ-040 TX_ARB_ERR_CHK_EN defined, ch0 vld=1 sop=0 in IDLE -> word dropped, err_pulse=1 for one cycle, out_vld stays 0.
